ps2_key_tracker: RTL and testbench
==================================

PS2_KEY_TRACKER -- requirements
Module: ps2_key_tracker

Interface
REQ-001 Parameter NUM_KEYS, default 4: number of tracked key bindings, range 2..8.
REQ-002 Parameter KEY_CODES, default {8'h74,8'h6B,8'h72,8'h73}: packed 8*NUM_KEYS scan codes; slice i (bits 8i+7:8i) binds key i (key0=0x73 forward, key1=0x72 backward, key2=0x6B left, key3=0x74 right).
REQ-003 Parameter EXT_MASK, default 0: NUM_KEYS bits; bit i set means key i matches only when preceded by 0xE0, and clear means it matches only without 0xE0.
REQ-004 Parameter LAST_WINS, default 1: 1 = most recently made key of a pair drives the axis output; 0 = both held cancels to 00.
REQ-005 Parameter TIMEOUT_CYCLES, default 100000: maximum clock cycles allowed between bytes of one multi-byte sequence.
REQ-006 CLOCK_50  input  1  system clock; all logic on its rising edge.
REQ-007 resetn  input  1  synchronous active-low reset.
REQ-008 ps2_key_data  input  8  received byte from the PS2 controller, valid only when ps2_key_pressed=1.
REQ-009 ps2_key_pressed  input  1  one-cycle strobe: ps2_key_data holds a new byte.
REQ-010 key_held  output  NUM_KEYS  bit i = 1 while key i is held down.
REQ-011 accel  output  2  10 forward (key0), 01 backward (key1), 00 none.
REQ-012 steer  output  2  10 right (key3), 01 left (key2), 00 none; tied to 00 when NUM_KEYS<4.
REQ-013 make_pulse  output  1  one-cycle pulse on a new press of a bound key.
REQ-014 break_pulse  output  1  one-cycle pulse on release of a held bound key.
REQ-015 key_index  output  $clog2(NUM_KEYS)  index of the key for the current make/break pulse; holds its last value otherwise.
REQ-016 seq_error  output  1  one-cycle pulse when an inter-byte timeout aborts a sequence.

Function
REQ-017 The parser FSM SHALL have states IDLE, EXT (0xE0 seen), BRK (0xF0 seen) and EXT_BRK (0xE0 then 0xF0 seen), and SHALL act only on cycles where ps2_key_pressed=1.
REQ-018 Transitions on a strobed byte: IDLE: E0->EXT, F0->BRK. EXT: F0->EXT_BRK, E0->EXT. BRK: F0->BRK. EXT_BRK: F0->EXT_BRK. Any other byte SHALL be treated as the final code and return the FSM to IDLE.
REQ-019 A final code in IDLE or EXT SHALL be a make; in BRK or EXT_BRK it SHALL be a break. The extended flag SHALL be 1 in EXT and EXT_BRK, else 0.
REQ-020 A final code SHALL match key i only when it equals KEY_CODES slice i and the extended flag equals EXT_MASK[i]; the lowest matching i wins; unmatched codes SHALL be ignored with no output change.
REQ-021 A make of a key not held SHALL set key_held[i] and pulse make_pulse with key_index=i; a repeated (typematic) make of a held key SHALL produce no pulse and no change.
REQ-022 A break of a held key SHALL clear key_held[i] and pulse break_pulse with key_index=i; a break of a key not held SHALL produce no pulse and no change.
REQ-023 key_held, accel, steer, the pulses and key_index SHALL be registered and update on the clock edge after the strobe of the final byte (latency 1 cycle).
REQ-024 Axis rule with LAST_WINS=1: each pair (key0/key1, key3/key2) SHALL track which member was made last; with both held that member drives the axis; on its release the other, still held, SHALL drive it in the same cycle as the release.
REQ-025 Axis rule with LAST_WINS=0: both held SHALL give 00; one held SHALL give its code; neither held SHALL give 00.
REQ-026 The timeout counter SHALL clear on every strobe and count while the FSM is not IDLE; on reaching TIMEOUT_CYCLES the FSM SHALL return to IDLE and pulse seq_error for one cycle, with no key_held change.
REQ-027 The counter width SHALL be $clog2(TIMEOUT_CYCLES+1) and it SHALL saturate, never wrap.
REQ-028 A strobe arriving in the same cycle the timeout fires SHALL be processed as a byte received in IDLE, and seq_error SHALL still pulse.

Reset
REQ-029 While resetn=0 at a rising edge, the FSM SHALL enter IDLE, the counter and the last-made trackers SHALL clear, and key_held, accel, steer, make_pulse, break_pulse, key_index and seq_error SHALL all be 0.
REQ-030 Reset SHALL take priority over a simultaneous strobe, and a partial sequence interrupted by reset SHALL be discarded.

Verification
REQ-031 Reset, then 0x73 -> next cycle key_held=0001, accel=10, make_pulse=1, key_index=0; then F0,73 -> key_held=0000, accel=00, break_pulse=1.
REQ-032 Bytes 73, 72 with LAST_WINS=1 -> accel=10 then 01; F0,72 -> accel=10 in the same cycle as the break_pulse; rerun with LAST_WINS=0 -> accel=00 while both keys are held.
REQ-033 Bytes 73, 73, 73 (typematic) -> exactly one make_pulse; then F0,F0,73 -> one break_pulse, and the FSM stays in BRK across the repeated F0.
REQ-034 With EXT_MASK=0100 (key2 extended): E0,6B -> key_held[2]=1, steer=01; a plain 6B -> no change; E0,F0,6B -> key_held[2]=0.
REQ-035 Send F0, then idle for TIMEOUT_CYCLES -> seq_error pulses once and the FSM returns to IDLE; a following 73 is a make (accel=10).
REQ-036 Send E0 and pull resetn low the cycle before the 6B strobe -> all outputs 0; after reset, 6B with EXT_MASK=0 -> make of key2.

Source files
------------

// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code tracker: parses make/break/extended sequences, keeps a held
// bitmap for the bound keys and derives registered accel/steer axis codes.
module ps2_key_tracker #(
  parameter int                    NUM_KEYS       = 4,
  parameter logic [8*NUM_KEYS-1:0] KEY_CODES      = {8'h74, 8'h6B, 8'h72, 8'h73},
  parameter logic [NUM_KEYS-1:0]   EXT_MASK       = '0,
  parameter bit                    LAST_WINS      = 1'b1,
  parameter int                    TIMEOUT_CYCLES = 100000
) (
  input  logic                        CLOCK_50,
  input  logic                        resetn,
  input  logic [7:0]                  ps2_key_data,
  input  logic                        ps2_key_pressed,
  output logic [NUM_KEYS-1:0]         key_held,
  output logic [1:0]                  accel,
  output logic [1:0]                  steer,
  output logic                        make_pulse,
  output logic                        break_pulse,
  output logic [$clog2(NUM_KEYS)-1:0] key_index,
  output logic                        seq_error
);

  localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int            KW   = $clog2(NUM_KEYS);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t              state_q, state_d, cur_p0;
  logic [CW-1:0]       cnt_q;
  logic                timeout_p0, final_p0, is_make_p0, is_ext_p0, found_p0;
  logic [KW-1:0]       idx_p0;
  logic [NUM_KEYS-1:0] match_p0, held_d;
  logic                last_a_q, last_a_d, last_s_q, last_s_d;
  logic                make_d, break_d;
  logic [KW-1:0]       index_d;
  logic [1:0]          accel_d, steer_d;
  logic [7:0]          held_pad;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == TMAX) ? c : c + 1'b1;
  endfunction

  // pos drives 10, neg drives 01; neg_last says the negative key was made last
  function automatic logic [1:0] axis(input logic pos, input logic neg, input logic neg_last);
    if (pos && neg) return LAST_WINS ? (neg_last ? 2'b01 : 2'b10) : 2'b00;
    else if (pos)   return 2'b10;
    else if (neg)   return 2'b01;
    else            return 2'b00;
  endfunction

  // Stage p0: byte classification; a timeout in this cycle makes the byte start fresh
  always_comb begin
    timeout_p0 = (state_q != IDLE) && (cnt_q == TMAX);
    cur_p0     = timeout_p0 ? IDLE : state_q;
    state_d    = cur_p0;
    final_p0   = 1'b0;
    if (ps2_key_pressed) begin
      case (cur_p0)
        IDLE:    if (ps2_key_data == 8'hE0)      state_d = EXT;
                 else if (ps2_key_data == 8'hF0) state_d = BRK;
                 else                            final_p0 = 1'b1;
        EXT:     if (ps2_key_data == 8'hF0)      state_d = EXT_BRK;
                 else if (ps2_key_data == 8'hE0) state_d = EXT;
                 else                            final_p0 = 1'b1;
        BRK:     if (ps2_key_data == 8'hF0)      state_d = BRK;
                 else                            final_p0 = 1'b1;
        EXT_BRK: if (ps2_key_data == 8'hF0)      state_d = EXT_BRK;
                 else                            final_p0 = 1'b1;
        default: state_d = IDLE;
      endcase
    end
    if (final_p0) state_d = IDLE;
    is_make_p0 = (cur_p0 == IDLE) || (cur_p0 == EXT);
    is_ext_p0  = (cur_p0 == EXT) || (cur_p0 == EXT_BRK);

    found_p0 = 1'b0;
    idx_p0   = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (KEY_CODES[8*i +: 8] == ps2_key_data && EXT_MASK[i] == is_ext_p0) begin
        found_p0 = 1'b1;
        idx_p0   = KW'(i);
      end
    end
    match_p0 = found_p0 ? (NUM_KEYS'(1) << idx_p0) : '0;
  end

  always_comb begin
    held_d   = key_held;
    last_a_d = last_a_q;
    last_s_d = last_s_q;
    make_d   = 1'b0;
    break_d  = 1'b0;
    index_d  = key_index;
    if (final_p0 && found_p0) begin
      if (is_make_p0 && (match_p0 & key_held) == '0) begin
        held_d  = key_held | match_p0;
        make_d  = 1'b1;
        index_d = idx_p0;
        if (int'(idx_p0) == 0)      last_a_d = 1'b0;
        else if (int'(idx_p0) == 1) last_a_d = 1'b1;
        else if (int'(idx_p0) == 2) last_s_d = 1'b1;
        else if (int'(idx_p0) == 3) last_s_d = 1'b0;
      end else if (!is_make_p0 && (match_p0 & key_held) != '0) begin
        held_d  = key_held & ~match_p0;
        break_d = 1'b1;
        index_d = idx_p0;
      end
    end
    held_pad = 8'(held_d);
    accel_d  = axis(held_pad[0], held_pad[1], last_a_d);
    steer_d  = (NUM_KEYS >= 4) ? axis(held_pad[3], held_pad[2], last_s_d) : 2'b00;
  end

  // Stage p1: registered outputs and parser state
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_a_q    <= 1'b0;
      last_s_q    <= 1'b0;
      key_held    <= '0;
      accel       <= 2'b00;
      steer       <= 2'b00;
      make_pulse  <= 1'b0;
      break_pulse <= 1'b0;
      key_index   <= '0;
      seq_error   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= (ps2_key_pressed || state_q == IDLE) ? '0 : sat_inc(cnt_q);
      last_a_q    <= last_a_d;
      last_s_q    <= last_s_d;
      key_held    <= held_d;
      accel       <= accel_d;
      steer       <= steer_d;
      make_pulse  <= make_d;
      break_pulse <= break_d;
      key_index   <= index_d;
      seq_error   <= timeout_p0;
    end
  end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Bench for ps2_key_tracker: vector table, directed corner sequences and a
// random run against a flag/timestamp reference model, on two configurations.
module tb_ps2_key_tracker;

  localparam int T = 40;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] data = 8'h00;
  logic       pressed = 1'b0;

  logic [3:0] held_a, held_b;
  logic [1:0] accel_a, accel_b, steer_a, steer_b, idx_a, idx_b;
  logic       mk_a, mk_b, bk_a, bk_b, se_a, se_b;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ps2_key_tracker #(.TIMEOUT_CYCLES(T)) dut_a (
    .CLOCK_50(clk), .resetn(resetn), .ps2_key_data(data), .ps2_key_pressed(pressed),
    .key_held(held_a), .accel(accel_a), .steer(steer_a), .make_pulse(mk_a),
    .break_pulse(bk_a), .key_index(idx_a), .seq_error(se_a));

  ps2_key_tracker #(.EXT_MASK(4'b0100), .LAST_WINS(1'b0), .TIMEOUT_CYCLES(T)) dut_b (
    .CLOCK_50(clk), .resetn(resetn), .ps2_key_data(data), .ps2_key_pressed(pressed),
    .key_held(held_b), .accel(accel_b), .steer(steer_b), .make_pulse(mk_b),
    .break_pulse(bk_b), .key_index(idx_b), .seq_error(se_b));

  // reference model: pending-prefix flags, held bits and make timestamps
  int   codes[4] = '{8'h73, 8'h72, 8'h6B, 8'h74};
  bit   mh[2][4];
  int   stamp[2][4];
  int   seqno = 0;
  bit   mext[2], mbrk[2], mmk[2], mbk[2], mse[2];
  int   midle[2];
  logic [1:0] midx[2];

  function automatic logic [1:0] maxis(input bit p, input bit n, input int ps, input int ns, input bit lw);
    if (p && n) return lw ? ((ns > ps) ? 2'b01 : 2'b10) : 2'b00;
    if (p) return 2'b10;
    if (n) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [12:0] mexp(input int m);
    logic [3:0] h;
    logic [1:0] a, s;
    for (int i = 0; i < 4; i++) h[i] = mh[m][i];
    a = maxis(mh[m][0], mh[m][1], stamp[m][0], stamp[m][1], m == 0);
    s = maxis(mh[m][3], mh[m][2], stamp[m][3], stamp[m][2], m == 0);
    return {h, a, s, mmk[m], mbk[m], midx[m], mse[m]};
  endfunction

  task automatic model_step(input int m, input bit r, input bit s, input logic [7:0] d);
    bit [3:0] mask;
    int hit;
    mask = (m == 0) ? 4'b0000 : 4'b0100;
    mmk[m] = 0; mbk[m] = 0; mse[m] = 0;
    if (!r) begin
      for (int i = 0; i < 4; i++) begin mh[m][i] = 0; stamp[m][i] = 0; end
      mext[m] = 0; mbrk[m] = 0; midle[m] = 0; midx[m] = 2'd0;
    end else begin
      if ((mext[m] || mbrk[m]) && midle[m] == T) begin
        mse[m] = 1; mext[m] = 0; mbrk[m] = 0;
      end
      if (s) begin
        midle[m] = 0;
        if (d == 8'hE0 && !mbrk[m]) mext[m] = 1;
        else if (d == 8'hF0) mbrk[m] = 1;
        else begin
          hit = -1;
          for (int i = 3; i >= 0; i--)
            if (codes[i] == int'(d) && mask[i] == mext[m]) hit = i;
          if (hit >= 0) begin
            if (!mbrk[m] && !mh[m][hit]) begin
              mh[m][hit] = 1; seqno++; stamp[m][hit] = seqno; mmk[m] = 1; midx[m] = 2'(hit);
            end else if (mbrk[m] && mh[m][hit]) begin
              mh[m][hit] = 0; mbk[m] = 1; midx[m] = 2'(hit);
            end
          end
          mext[m] = 0; mbrk[m] = 0;
        end
      end else if (mext[m] || mbrk[m]) begin
        if (midle[m] < T) midle[m]++;
      end else midle[m] = 0;
    end
  endtask

  function automatic logic [12:0] act_a();
    return {held_a, accel_a, steer_a, mk_a, bk_a, idx_a, se_a};
  endfunction

  function automatic logic [12:0] act_b();
    return {held_b, accel_b, steer_b, mk_b, bk_b, idx_b, se_b};
  endfunction

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic tick(input bit r, input bit s, input logic [7:0] d);
    resetn = r; pressed = s; data = d;
    @(posedge clk);
    model_step(0, r, s, d);
    model_step(1, r, s, d);
    #1;
    chk("model_a", 16'(act_a()), 16'(mexp(0)));
    chk("model_b", 16'(act_b()), 16'(mexp(1)));
    pressed = 1'b0;
  endtask

  task automatic do_reset();
    tick(0, 0, 8'h00);
    tick(0, 0, 8'h00);
  endtask

  typedef struct {
    bit         r;
    bit         s;
    logic [7:0] d;
    logic [12:0] exp;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input bit r, input logic [7:0] d, input logic [3:0] h, input logic [1:0] a,
                     input logic [1:0] st, input bit mk, input bit bk, input logic [1:0] ix);
    vec_t v;
    v.r = r; v.s = r; v.d = d;
    v.exp = {h, a, st, mk, bk, ix, 1'b0};
    vecs.push_back(v);
  endtask

  initial begin
    int pulses, first;
    logic [7:0] rd;
    bit rr, rs;

    // configuration A: default bindings, no extended keys, last-made wins
    add(0, 8'h00, 4'b0000, 2'b00, 2'b00, 0, 0, 2'd0);
    add(1, 8'h73, 4'b0001, 2'b10, 2'b00, 1, 0, 2'd0);
    add(1, 8'hF0, 4'b0001, 2'b10, 2'b00, 0, 0, 2'd0);
    add(1, 8'h73, 4'b0000, 2'b00, 2'b00, 0, 1, 2'd0);
    add(1, 8'h73, 4'b0001, 2'b10, 2'b00, 1, 0, 2'd0);
    add(1, 8'h72, 4'b0011, 2'b01, 2'b00, 1, 0, 2'd1);
    add(1, 8'hF0, 4'b0011, 2'b01, 2'b00, 0, 0, 2'd1);
    add(1, 8'h72, 4'b0001, 2'b10, 2'b00, 0, 1, 2'd1);
    add(1, 8'h73, 4'b0001, 2'b10, 2'b00, 0, 0, 2'd1);
    add(1, 8'h73, 4'b0001, 2'b10, 2'b00, 0, 0, 2'd1);
    add(1, 8'hF0, 4'b0001, 2'b10, 2'b00, 0, 0, 2'd1);
    add(1, 8'hF0, 4'b0001, 2'b10, 2'b00, 0, 0, 2'd1);
    add(1, 8'h73, 4'b0000, 2'b00, 2'b00, 0, 1, 2'd0);
    add(1, 8'hE0, 4'b0000, 2'b00, 2'b00, 0, 0, 2'd0);
    add(1, 8'h6B, 4'b0000, 2'b00, 2'b00, 0, 0, 2'd0);
    add(1, 8'h6B, 4'b0100, 2'b00, 2'b01, 1, 0, 2'd2);
    add(1, 8'h74, 4'b1100, 2'b00, 2'b10, 1, 0, 2'd3);
    add(1, 8'hF0, 4'b1100, 2'b00, 2'b10, 0, 0, 2'd3);
    add(1, 8'h74, 4'b0100, 2'b00, 2'b01, 0, 1, 2'd3);
    add(1, 8'hF0, 4'b0100, 2'b00, 2'b01, 0, 0, 2'd3);
    add(1, 8'h6B, 4'b0000, 2'b00, 2'b00, 0, 1, 2'd2);
    add(1, 8'hF0, 4'b0000, 2'b00, 2'b00, 0, 0, 2'd2);
    add(1, 8'h99, 4'b0000, 2'b00, 2'b00, 0, 0, 2'd2);

    do_reset();
    foreach (vecs[i]) begin
      tick(vecs[i].r, vecs[i].s, vecs[i].d);
      chk($sformatf("vec%0d", i), 16'(act_a()), 16'(vecs[i].exp));
    end

    // both forward/backward held: A follows the last make, B cancels
    do_reset();
    tick(1, 1, 8'h73);
    tick(1, 1, 8'h72);
    chk("lw1_both", 16'(accel_a), 16'(2'b01));
    chk("lw0_both", 16'(accel_b), 16'(2'b00));
    chk("lw0_held", 16'(held_b), 16'(4'b0011));
    tick(1, 1, 8'hF0);
    tick(1, 1, 8'h72);
    chk("lw1_release", 16'({accel_a, bk_a}), 16'({2'b10, 1'b1}));
    chk("lw0_release", 16'({accel_b, bk_b}), 16'({2'b10, 1'b1}));

    // extended binding for key2 on B
    do_reset();
    tick(1, 1, 8'hE0);
    tick(1, 1, 8'h6B);
    chk("ext_make", 16'({held_b, steer_b, mk_b}), 16'({4'b0100, 2'b01, 1'b1}));
    tick(1, 1, 8'h6B);
    chk("ext_plain", 16'({held_b, steer_b, mk_b}), 16'({4'b0100, 2'b01, 1'b0}));
    tick(1, 1, 8'hE0);
    tick(1, 1, 8'hF0);
    tick(1, 1, 8'h6B);
    chk("ext_break", 16'({held_b, bk_b}), 16'({4'b0000, 1'b1}));

    // inter-byte timeout
    do_reset();
    tick(1, 1, 8'hF0);
    pulses = 0; first = -1;
    for (int j = 1; j <= T + 5; j++) begin
      tick(1, 0, 8'h00);
      if (se_a) begin pulses++; if (first < 0) first = j; end
    end
    chk("timeout_count", 16'(pulses), 16'd1);
    chk("timeout_when", 16'(first), 16'(T + 1));
    tick(1, 1, 8'h73);
    chk("after_timeout", 16'({accel_a, mk_a, held_a}), 16'({2'b10, 1'b1, 4'b0001}));

    // strobe landing on the timeout cycle is parsed from IDLE
    do_reset();
    tick(1, 1, 8'hF0);
    for (int j = 0; j < T; j++) tick(1, 0, 8'h00);
    chk("pre_fire", 16'(se_a), 16'd0);
    tick(1, 1, 8'h73);
    chk("fire_strobe", 16'({se_a, mk_a, held_a}), 16'({1'b1, 1'b1, 4'b0001}));

    // reset mid-sequence wins over the strobe and discards the prefix
    do_reset();
    tick(1, 1, 8'h73);
    tick(1, 1, 8'hE0);
    tick(0, 1, 8'h6B);
    chk("rst_prio_a", 16'(act_a()), 16'd0);
    chk("rst_prio_b", 16'(act_b()), 16'd0);
    tick(1, 1, 8'h6B);
    chk("post_rst", 16'({held_a, steer_a, mk_a, idx_a}), 16'({4'b0100, 2'b01, 1'b1, 2'd2}));

    // random traffic against the model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 99) < 2) begin
        int n;
        n = $urandom_range(30, 50);
        for (int q = 0; q < n; q++) tick(1, 0, 8'h00);
      end else begin
        rr = ($urandom_range(0, 499) != 0);
        rs = ($urandom_range(0, 9) < 4);
        case ($urandom_range(0, 7))
          0: rd = 8'h73;
          1: rd = 8'h72;
          2: rd = 8'h6B;
          3: rd = 8'h74;
          4: rd = 8'hE0;
          5, 6: rd = 8'hF0;
          default: rd = 8'($urandom());
        endcase
        tick(rr, rs, rd);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
